vend_txn_controller: RTL

Transaction controller for a two-product coin vending machine.
- Accepts coins over a valid-qualified interface and accumulates credit.
- Arbitrates product selection against configurable prices.
- Sequences the product-release mechanism with a req/ack handshake.
- Returns change coin by coin through a second req/ack handshake.
- Sits between the coin acceptor / keypad front end and the dispense and change-hopper actuators.

---
 rtl/vend_pkg.sv | 40 ++++
 rtl/vend_change_dispenser.sv | 68 ++++++
 rtl/vend_txn_controller.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared coin codes, state encoding and coin arithmetic for the vending transaction controller.
package vend_pkg;

   localparam logic [1:0] TEN     = 2'b00;
   localparam logic [1:0] TWENTY  = 2'b01;
   localparam logic [1:0] FIFTY   = 2'b10;
   localparam logic [1:0] INVALID = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      CREDIT = 2'b01,
      VEND   = 2'b10,
      CHANGE = 2'b11
   } vend_state_e;

   function automatic logic [7:0] coin_value(input logic [1:0] code);
      logic [7:0] value;
      case (code)
         TEN:     value = 8'd10;
         TWENTY:  value = 8'd20;
         FIFTY:   value = 8'd50;
         default: value = 8'd0;
      endcase
      return value;
   endfunction

   // Largest coin not exceeding the amount still owed.
   function automatic logic [1:0] greedy_coin(input logic [7:0] amount);
      logic [1:0] code;
      if (amount >= 8'd50) begin
         code = FIFTY;
      end else if (amount >= 8'd20) begin
         code = TWENTY;
      end else begin
         code = TEN;
      end
      return code;
   endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Returns an amount coin by coin over the chg_req/chg_ack handshake, largest coin first.
module vend_change_dispenser
   import vend_pkg::*;
(
   input  logic       CLK,
   input  logic       RESET,
   input  logic       start,
   input  logic [7:0] amount,
   input  logic       chg_ack,
   output logic       chg_req,
   output logic [1:0] chg_coin,
   output logic       done,
   output logic [7:0] remaining
);

   logic [7:0] rem_q, rem_d;
   logic [7:0] rem_after_s;
   logic       chg_req_q, chg_req_d;
   logic [1:0] chg_coin_q, chg_coin_d;
   logic       gap_q, gap_d;
   logic       ack_s;

   assign ack_s       = chg_req_q & chg_ack;
   assign rem_after_s = rem_q - coin_value(chg_coin_q);

   // Load on start, settle a coin on each ack, re-raise the request after a one-cycle gap.
   always_comb begin
      rem_d      = rem_q;
      chg_req_d  = chg_req_q;
      chg_coin_d = chg_coin_q;
      gap_d      = 1'b0;
      if (start) begin
         rem_d      = amount;
         chg_req_d  = 1'b1;
         chg_coin_d = greedy_coin(amount);
      end else if (ack_s) begin
         rem_d      = rem_after_s;
         chg_req_d  = 1'b0;
         chg_coin_d = greedy_coin(rem_after_s);
         gap_d      = (rem_after_s != 8'd0);
      end else if (gap_q) begin
         chg_req_d  = 1'b1;
      end else begin
         chg_req_d  = chg_req_q;
      end
   end

   // Dispenser state registers.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         rem_q      <= 8'd0;
         chg_req_q  <= 1'b0;
         chg_coin_q <= 2'b00;
         gap_q      <= 1'b0;
      end else begin
         rem_q      <= rem_d;
         chg_req_q  <= chg_req_d;
         chg_coin_q <= chg_coin_d;
         gap_q      <= gap_d;
      end
   end

   assign chg_req   = chg_req_q;
   assign chg_coin  = chg_coin_q;
   assign done      = ack_s & (rem_after_s == 8'd0);
   assign remaining = rem_d;

endmodule

// File: rtl/vend_txn_controller.sv
// Two-product coin vending transaction controller: credit, selection, dispense and change.
module vend_txn_controller
   import vend_pkg::*;
#(
   parameter int unsigned PRICE_A        = 40,
   parameter int unsigned PRICE_B        = 60,
   parameter int unsigned MAX_CREDIT     = 90,
   parameter int unsigned TIMEOUT_CYCLES = 1000
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       coin_valid,
   input  logic [1:0] coin,
   output logic       coin_accept,
   output logic       coin_reject,
   input  logic       sel_valid,
   input  logic       sel,
   input  logic       cancel,
   output logic       vend_req,
   output logic       vend_sel,
   input  logic       vend_ack,
   output logic       chg_req,
   output logic [1:0] chg_coin,
   input  logic       chg_ack,
   output logic [7:0] credit,
   output logic       busy
);

   localparam int unsigned    TW        = $clog2(TIMEOUT_CYCLES);
   localparam logic [TW-1:0]  TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [7:0]     PRICE_A_C = 8'(PRICE_A);
   localparam logic [7:0]     PRICE_B_C = 8'(PRICE_B);
   localparam logic [8:0]     MAX_C     = 9'(MAX_CREDIT);

   if (PRICE_A > MAX_CREDIT || PRICE_B > MAX_CREDIT || MAX_CREDIT > 250 || TIMEOUT_CYCLES < 2) begin : g_param_check
      $error("vend_txn_controller: illegal price/credit/timeout parameters");
   end

   vend_state_e   state_q, state_d;
   logic [7:0]    credit_q, credit_d;
   logic [TW-1:0] tmo_q, tmo_d;
   logic          coin_accept_q, coin_accept_d;
   logic          coin_reject_q, coin_reject_d;
   logic          vend_req_q, vend_req_d;
   logic          vend_sel_q, vend_sel_d;
   logic          busy_q, busy_d;

   logic [8:0]    coin_sum_s;
   logic [7:0]    price_s, chg_rem_s;
   logic          coin_ok_s, sel_ok_s, in_credit_s;
   logic          take_cancel_s, take_sel_s, take_coin_s, take_tmo_s;
   logic          vend_done_s, chg_start_s, chg_done_s;

   // Same-cycle priority in CREDIT is cancel, then an affordable selection, then a coin, then timeout.
   assign in_credit_s   = (state_q == CREDIT);
   assign coin_sum_s    = {1'b0, credit_q} + {1'b0, coin_value(coin)};
   assign coin_ok_s     = coin_valid && (coin != INVALID) && (coin_sum_s <= MAX_C);
   assign price_s       = sel ? PRICE_B_C : PRICE_A_C;
   assign sel_ok_s      = sel_valid && (credit_q >= price_s);
   assign take_cancel_s = in_credit_s && cancel;
   assign take_sel_s    = in_credit_s && !cancel && sel_ok_s;
   assign take_coin_s   = coin_ok_s && ((state_q == IDLE) || (in_credit_s && !cancel && !sel_ok_s));
   assign take_tmo_s    = in_credit_s && !cancel && !sel_ok_s && !coin_ok_s && (tmo_q == TMO_LAST);
   assign vend_done_s   = (state_q == VEND) && vend_ack;
   assign chg_start_s   = take_cancel_s || take_tmo_s || (vend_done_s && (credit_q != 8'd0));

   // State and registered outputs.
   always_ff @(posedge CLK or negedge RESET) begin
      if (!RESET) begin
         state_q       <= IDLE;
         credit_q      <= 8'd0;
         tmo_q         <= '0;
         coin_accept_q <= 1'b0;
         coin_reject_q <= 1'b0;
         vend_req_q    <= 1'b0;
         vend_sel_q    <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         credit_q      <= credit_d;
         tmo_q         <= tmo_d;
         coin_accept_q <= coin_accept_d;
         coin_reject_q <= coin_reject_d;
         vend_req_q    <= vend_req_d;
         vend_sel_q    <= vend_sel_d;
         busy_q        <= busy_d;
      end
   end

   // Next-state selection.
   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (take_coin_s) state_d = CREDIT;
            else             state_d = IDLE;
         end
         CREDIT: begin
            if (take_cancel_s || take_tmo_s) state_d = CHANGE;
            else if (take_sel_s)             state_d = VEND;
            else                             state_d = CREDIT;
         end
         VEND: begin
            if (vend_done_s) state_d = (credit_q != 8'd0) ? CHANGE : IDLE;
            else             state_d = VEND;
         end
         CHANGE: begin
            if (chg_done_s) state_d = IDLE;
            else            state_d = CHANGE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Credit, timeout and handshake outputs; any coin not taken this cycle is refused.
   always_comb begin
      credit_d      = credit_q;
      tmo_d         = tmo_q;
      coin_accept_d = take_coin_s;
      coin_reject_d = coin_valid && !take_coin_s;
      vend_req_d    = vend_req_q;
      vend_sel_d    = vend_sel_q;
      busy_d        = (state_d == VEND) || (state_d == CHANGE);
      if (take_coin_s) begin
         credit_d = coin_sum_s[7:0];
         tmo_d    = '0;
      end else if (take_sel_s) begin
         credit_d   = credit_q - price_s;
         vend_req_d = 1'b1;
         vend_sel_d = sel;
      end else if (vend_done_s) begin
         vend_req_d = 1'b0;
         vend_sel_d = 1'b0;
      end else if (state_q == CHANGE) begin
         credit_d = chg_rem_s;
      end else if (in_credit_s) begin
         tmo_d = tmo_q + TW'(1);
      end else begin
         tmo_d = '0;
      end
   end

   vend_change_dispenser u_change (
      .CLK       (CLK),
      .RESET     (RESET),
      .start     (chg_start_s),
      .amount    (credit_q),
      .chg_ack   (chg_ack),
      .chg_req   (chg_req),
      .chg_coin  (chg_coin),
      .done      (chg_done_s),
      .remaining (chg_rem_s)
   );

   assign coin_accept = coin_accept_q;
   assign coin_reject = coin_reject_q;
   assign vend_req    = vend_req_q;
   assign vend_sel    = vend_sel_q;
   assign credit      = credit_q;
   assign busy        = busy_q;

endmodule
